ddr4_lane_read_eye_trainer: RTL
===============================

DDR4_LANE_READ_EYE_TRAINER -- requirements
Module: ddr4_lane_read_eye_trainer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: number of FAB_CLK cycles waited after each flag clear before sampling.
REQ-002 SHALL have parameter MAX_TAPS, default 128: number of delay-line taps swept.
REQ-003 SHALL have parameter MIN_EYE_WIDTH, default 4: smallest eye width in taps that is accepted.
REQ-004 SHALL have port FAB_CLK, input, 1: the only clock; all logic is rising-edge.
REQ-005 SHALL have port SYNC_RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1: training request.
REQ-007 SHALL have ports EYE_MONITOR_EARLY and EYE_MONITOR_LATE, input, 1 each: sticky eye-monitor flags from the lane IOD.
REQ-008 SHALL have port DELAY_LINE_OUT_OF_RANGE, input, 1: IOD delay line at its limit.
REQ-009 SHALL have ports DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS, output, 1 each: IOD delay and eye-monitor controls.
REQ-010 SHALL have ports BUSY, DONE and FAIL, output, 1 each: status.
REQ-011 SHALL have ports TAP_COUNT and EYE_WIDTH, output, 8 each: current tap and measured eye width.

Function
REQ-012 SHALL implement the states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, CENTER, DONE_S and FAIL_S, with a phase bit that is either SEEK_OPEN or SEEK_CLOSE.
REQ-013 SHALL accept START only in IDLE, DONE_S or FAIL_S; in those states START clears DONE and FAIL and moves to LOAD. START is ignored in all other states.
REQ-014 In LOAD, SHALL pulse DELAY_LINE_LOAD for exactly 1 cycle, set TAP_COUNT=0 and phase=SEEK_OPEN, then go to CLEAR.
REQ-015 In CLEAR, SHALL pulse EYE_MONITOR_CLEAR_FLAGS for exactly 1 cycle, then go to SETTLE.
REQ-016 In SETTLE, SHALL wait SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 In SAMPLE, SHALL compute pass = !(EYE_MONITOR_EARLY | EYE_MONITOR_LATE).
  - SEEK_OPEN with pass: record eye_start=TAP_COUNT and set phase=SEEK_CLOSE.
  - SEEK_CLOSE without pass: record eye_end=TAP_COUNT and go to CENTER.
  - Otherwise: go to STEP.
REQ-018 In STEP, if TAP_COUNT==MAX_TAPS-1 or DELAY_LINE_OUT_OF_RANGE=1:
  - SEEK_OPEN: go to FAIL_S.
  - SEEK_CLOSE: set eye_end=TAP_COUNT+1 and go to CENTER.
REQ-019 In STEP, when REQ-018 does not apply, SHALL pulse DELAY_LINE_MOVE for 1 cycle with DELAY_LINE_DIRECTION=1 (increment), increment TAP_COUNT, and go to CLEAR.
REQ-020 On entry to CENTER, SHALL register EYE_WIDTH = eye_end - eye_start; if EYE_WIDTH < MIN_EYE_WIDTH it SHALL go to FAIL_S.
REQ-021 Otherwise, SHALL compute target = eye_start + floor(EYE_WIDTH/2) and issue TAP_COUNT - target pulses on DELAY_LINE_MOVE with DELAY_LINE_DIRECTION=0.
  - Each pulse is 1 cycle high followed by at least 1 cycle low.
  - TAP_COUNT decrements once per pulse.
  - When TAP_COUNT==target, the block goes to DONE_S.
REQ-022 In CENTER, SHALL ignore DELAY_LINE_OUT_OF_RANGE.
REQ-023 DELAY_LINE_DIRECTION SHALL hold its last driven value whenever DELAY_LINE_MOVE=0.
REQ-024 At most one of DELAY_LINE_MOVE, DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS SHALL be high in any cycle.
REQ-025 BUSY SHALL be 1 in all states except IDLE, DONE_S and FAIL_S.
REQ-026 DONE SHALL be 1 only in DONE_S and FAIL SHALL be 1 only in FAIL_S; each holds until the next accepted START or reset.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While SYNC_RST=1, SHALL hold state=IDLE, phase=SEEK_OPEN, and drive every output to 0, including TAP_COUNT and EYE_WIDTH.
REQ-029 Reset asserted mid-training SHALL abort on the next clock edge, with no further MOVE, LOAD or CLEAR pulses.
REQ-030 SYNC_RST SHALL take priority over START in the same cycle.

Configuration
REQ-031 With macro DDR4_TRAIN_VOTE_EN defined, each tap SHALL be evaluated 3 times (each evaluation is CLEAR, SETTLE, SAMPLE), and pass SHALL be the majority of the 3 samples.
REQ-032 Without DDR4_TRAIN_VOTE_EN, each tap SHALL be evaluated once, as in REQ-017.

Verification
REQ-033 Flags clear for taps 10..29 only, START: 30 increment pulses, then EYE_WIDTH=20, then 10 decrement pulses, TAP_COUNT=20, DONE=1, FAIL=0.
REQ-034 Flags never clear, START: 127 increment pulses, then FAIL=1, DONE=0, BUSY=0.
REQ-035 Flags clear for taps 5..7 only: EYE_WIDTH=3, FAIL=1, no decrement pulses.
REQ-036 Flags clear from tap 100 and DELAY_LINE_OUT_OF_RANGE=1 at tap 120: EYE_WIDTH=21, 10 decrement pulses, TAP_COUNT=110, DONE=1.
REQ-037 SYNC_RST asserted during CENTER: the next cycle has all outputs 0 and state IDLE; a following START sweeps normally from LOAD.
REQ-038 With DDR4_TRAIN_VOTE_EN, EYE_MONITOR_LATE=1 in 1 of the 3 samples at every tap in 10..29: the result matches REQ-033.

Source files
------------

// File: rtl/ddr4_lane_read_eye_trainer.sv
// ddr4_lane_read_eye_trainer: sweeps one DDR4 lane's IOD read delay, finds the passing eye and centers on it.
// Ports: FAB_CLK/SYNC_RST clock and sync active-high reset; START training request;
//   EYE_MONITOR_EARLY/LATE sticky eye flags and DELAY_LINE_OUT_OF_RANGE from the IOD;
//   DELAY_LINE_MOVE/DIRECTION/LOAD and EYE_MONITOR_CLEAR_FLAGS drive the IOD;
//   BUSY/DONE/FAIL status; TAP_COUNT current tap; EYE_WIDTH measured eye in taps.
// Define DDR4_TRAIN_VOTE_EN to evaluate each tap three times and take the majority.
module ddr4_lane_read_eye_trainer #(
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_TAPS = 128,
  parameter int MIN_EYE_WIDTH = 4
) (
  input  logic       FAB_CLK,
  input  logic       SYNC_RST,
  input  logic       START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [7:0] TAP_COUNT,
  output logic [7:0] EYE_WIDTH
);
  typedef enum logic [3:0] {IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, CENTER, DONE_S, FAIL_S} state_t;
  state_t r_state, w_state;
  logic r_phase, w_phase, r_gap, w_gap, w_move, w_dir;
  logic r_move, r_dir, r_load, r_clr, r_busy, r_done, r_fail;
  logic [7:0] r_tap, w_tap, r_eye_start, w_eye_start, r_width, w_width, w_target;
  logic [15:0] r_cnt, w_cnt;
  logic w_raw, w_pass, w_eval;
  assign w_raw = !(EYE_MONITOR_EARLY | EYE_MONITOR_LATE);
  assign w_target = r_eye_start + {1'b0, r_width[7:1]};
`ifdef DDR4_TRAIN_VOTE_EN
  logic [1:0] r_vote, r_pcnt;
  assign w_eval = r_vote == 2'd2;
  assign w_pass = (r_pcnt + {1'b0, w_raw}) >= 2'd2;
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST || r_state == LOAD) begin
      r_vote <= '0;
      r_pcnt <= '0;
    end else if (r_state == SAMPLE) begin
      r_vote <= w_eval ? 2'd0 : r_vote + 2'd1;
      r_pcnt <= w_eval ? 2'd0 : r_pcnt + {1'b0, w_raw};
    end
  end
`else
  assign w_eval = 1'b1;
  assign w_pass = w_raw;
`endif
  // Output pulses are registered from the current state, so LOAD shows during CLEAR,
  // CLEAR_FLAGS during the first SETTLE cycle and an up-step MOVE during CLEAR; they never overlap.
  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_tap = r_tap;
    w_eye_start = r_eye_start;
    w_width = r_width;
    w_cnt = '0;
    w_gap = 1'b0;
    w_move = 1'b0;
    w_dir = r_dir;
    case (r_state)
      IDLE, DONE_S, FAIL_S: if (START) begin
        w_state = LOAD;
        w_tap = '0;
        w_phase = 1'b0;
        w_width = '0;
      end
      LOAD: w_state = CLEAR;
      CLEAR: w_state = SETTLE;
      SETTLE: begin
        w_cnt = r_cnt + 16'd1;
        w_state = (r_cnt == 16'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      end
      SAMPLE: if (!w_eval) w_state = CLEAR;
      else if (!r_phase) begin
        w_state = STEP;
        if (w_pass) begin
          w_eye_start = r_tap;
          w_phase = 1'b1;
        end
      end else if (!w_pass) begin
        w_state = CENTER;
        w_width = r_tap - r_eye_start;
      end else w_state = STEP;
      STEP: if (r_tap == 8'(MAX_TAPS - 1) || DELAY_LINE_OUT_OF_RANGE) begin
        w_state = r_phase ? CENTER : FAIL_S;
        if (r_phase) w_width = r_tap + 8'd1 - r_eye_start;
      end else begin
        w_state = CLEAR;
        w_move = 1'b1;
        w_dir = 1'b1;
        w_tap = r_tap + 8'd1;
      end
      // r_gap forces a low cycle between successive down-steps.
      CENTER: if (r_width < 8'(MIN_EYE_WIDTH)) w_state = FAIL_S;
      else if (r_tap == w_target) w_state = DONE_S;
      else if (!r_gap) begin
        w_move = 1'b1;
        w_dir = 1'b0;
        w_tap = r_tap - 8'd1;
        w_gap = 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      r_state <= IDLE;
      r_phase <= 1'b0;
      r_tap <= '0;
      r_eye_start <= '0;
      r_width <= '0;
      r_cnt <= '0;
      r_gap <= 1'b0;
      r_move <= 1'b0;
      r_dir <= 1'b0;
      r_load <= 1'b0;
      r_clr <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_tap <= w_tap;
      r_eye_start <= w_eye_start;
      r_width <= w_width;
      r_cnt <= w_cnt;
      r_gap <= w_gap;
      r_move <= w_move;
      r_dir <= w_dir;
      r_load <= r_state == LOAD;
      r_clr <= r_state == CLEAR;
      r_busy <= (w_state != IDLE) && (w_state != DONE_S) && (w_state != FAIL_S);
      r_done <= w_state == DONE_S;
      r_fail <= w_state == FAIL_S;
    end
  end
  assign DELAY_LINE_MOVE = r_move;
  assign DELAY_LINE_DIRECTION = r_dir;
  assign DELAY_LINE_LOAD = r_load;
  assign EYE_MONITOR_CLEAR_FLAGS = r_clr;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign FAIL = r_fail;
  assign TAP_COUNT = r_tap;
  assign EYE_WIDTH = r_width;
endmodule
